// File: rtl/dsc_mul_bist_pkg.sv
// Shared types and LFSR helpers for the stochastic-multiplier self-test initiator.
// LFSR widths 4..16 are supported; feedback taps are listed per width below.
package dsc_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_e;

  // Maximal-length Fibonacci taps; bit (n-1) set for tap n.
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      4:       return 16'h000C;  // 4,3
      5:       return 16'h0014;  // 5,3
      6:       return 16'h0030;  // 6,5
      7:       return 16'h0060;  // 7,6
      8:       return 16'h00B8;  // 8,6,5,4
      9:       return 16'h0110;  // 9,5
      10:      return 16'h0240;  // 10,7
      11:      return 16'h0500;  // 11,9
      12:      return 16'h0829;  // 12,6,4,1
      13:      return 16'h100D;  // 13,4,3,1
      14:      return 16'h2015;  // 14,5,3,1
      15:      return 16'h6000;  // 15,14
      16:      return 16'hD008;  // 16,15,13,4
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_next(input int width, input logic [15:0] state);
    logic [15:0] wmask;
    logic        fb;
    wmask = 16'((32'h1 << width) - 32'h1);
    fb    = ^(state & lfsr_taps(width));
    return ((state << 1) | {15'b0, fb}) & wmask;
  endfunction

endpackage

// File: rtl/dsc_mul_bist_if.sv
// Operand/result bus between the self-test initiator and the multiplier under test.
interface dsc_mul_bist_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_rst;
  logic               mul_en;
  logic [2*WIDTH-1:0] mul_z;
  logic               mul_ov;

  modport master (output mul_a, mul_b, mul_rst, mul_en, input mul_z, mul_ov);
  modport slave  (input mul_a, mul_b, mul_rst, mul_en, output mul_z, mul_ov);
endinterface

// File: rtl/dsc_mul_bist_lfsr_gen.sv
// Operand-pair generator: Fibonacci LFSR, reloadable with its seed, stepped on demand.
module lfsr_gen
  import dsc_bist_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] SEED = W'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] q
);
  logic [W-1:0] state_q, state_d;
  logic [15:0]  nxt16;

  always_comb begin
    nxt16   = lfsr_next(W, 16'(state_q));
    state_d = state_q;
    if (load)      state_d = SEED;
    else if (step) state_d = nxt16[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= SEED;
    else      state_q <= state_d;
  end

  assign q = state_q;
endmodule

// File: rtl/dsc_mul_bist.sv
// Self-test initiator: drives LFSR operand pairs through the multiplier protocol,
// checks each product exactly and accumulates errors, first-failure record and latency.
module dsc_mul_bist
  import dsc_bist_pkg::*;
#(
  parameter int                 WIDTH     = 4,
  parameter int                 NUM_TESTS = 1000,
  parameter int                 CNT_W     = 16,
  parameter int                 ACC_W     = 26,
  parameter int                 TIMEOUT   = 1024,
  parameter logic [2*WIDTH-1:0] SEED      = (2*WIDTH)'(8'hA5)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic                 timeout_seen,
  output logic [ACC_W-1:0]     cycle_acc,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic [2*WIDTH-1:0]   fail_z,
  dsc_mul_bist_if.master       mul
);
  localparam int LW    = 2 * WIDTH;
  localparam int IDX_W = $clog2(NUM_TESTS + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               tmo_q, tmo_d;
  logic               hung_q, hung_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   fa_q, fa_d, fb_q, fb_d;
  logic [LW-1:0]      fz_q, fz_d;

  logic               lfsr_load, lfsr_step;
  logic [LW-1:0]      lfsr_q;
  logic               mul_rst_o, mul_en_o;
  logic [LW-1:0]      prod;
  logic [ACC_W:0]     acc_sum;
  logic [CNT_W-1:0]   cnt_inc;
  logic [IDX_W-1:0]   idx_inc;
  logic               bad;

  lfsr_gen #(.W(LW), .SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    acc_d     = acc_q;
    tmo_d     = tmo_q;
    hung_d    = hung_q;
    done_d    = done_q;
    fa_d      = fa_q;
    fb_d      = fb_q;
    fz_d      = fz_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    mul_rst_o = 1'b1;
    mul_en_o  = 1'b0;
    prod      = LW'(a_q) * LW'(b_q);
    acc_sum   = {1'b0, acc_q} + (ACC_W+1)'(cnt_q);
    cnt_inc   = cnt_q + CNT_W'(1);
    idx_inc   = idx_q + IDX_W'(1);
    bad       = hung_q || (mul.mul_z != prod);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d     = '0;
          acc_d     = '0;
          tmo_d     = 1'b0;
          fa_d      = '0;
          fb_d      = '0;
          fz_d      = '0;
          done_d    = 1'b0;
          idx_d     = '0;
          lfsr_load = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        a_d     = lfsr_q[WIDTH-1:0];
        b_d     = lfsr_q[LW-1:WIDTH];
        cnt_d   = '0;
        hung_d  = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        mul_rst_o = 1'b0;
        mul_en_o  = 1'b1;
        cnt_d     = cnt_inc;
        // ov takes priority over a coincident timeout
        if (mul.mul_ov) begin
          state_d = S_CHECK;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          hung_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // keep the multiplier out of reset so z stays valid while sampled
        mul_rst_o = 1'b0;
        if (bad) begin
          if (err_q == '0) begin
            fa_d = a_q;
            fb_d = b_q;
            fz_d = mul.mul_z;
          end
          if (err_q != '1) err_d = err_q + CNT_W'(1);
        end
        tmo_d     = tmo_q | hung_q;
        acc_d     = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        lfsr_step = 1'b1;
        idx_d     = idx_inc;
        state_d   = (idx_inc == IDX_W'(NUM_TESTS)) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      acc_q   <= '0;
      tmo_q   <= 1'b0;
      hung_q  <= 1'b0;
      done_q  <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      fz_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      tmo_q   <= tmo_d;
      hung_q  <= hung_d;
      done_q  <= done_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fz_q    <= fz_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign pass         = done_q && (err_q == '0);
  assign err_count    = err_q;
  assign timeout_seen = tmo_q;
  assign cycle_acc    = acc_q;
  assign fail_a       = fa_q;
  assign fail_b       = fb_q;
  assign fail_z       = fz_q;
  assign mul.mul_a    = a_q;
  assign mul.mul_b    = b_q;
  assign mul.mul_rst  = mul_rst_o;
  assign mul.mul_en   = mul_en_o;
endmodule

// File: tb/tb_dsc_mul_bist.sv
// Directed bench for dsc_mul_bist with a behavioural multiplier stub and an operand scoreboard.
module tb_dsc_mul_bist;
  localparam int W = 4, N = 3, CNT_W = 16, ACC_W = 26, TMO = 8;

  logic               clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic               busy, done, pass, timeout_seen;
  logic [CNT_W-1:0]   err_count;
  logic [ACC_W-1:0]   cycle_acc;
  logic [W-1:0]       fail_a, fail_b;
  logic [2*W-1:0]     fail_z;

  dsc_mul_bist_if #(.WIDTH(W)) mbus ();

  dsc_mul_bist #(.WIDTH(W), .NUM_TESTS(N), .CNT_W(CNT_W), .ACC_W(ACC_W),
                 .TIMEOUT(TMO), .SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .timeout_seen(timeout_seen), .cycle_acc(cycle_acc),
    .fail_a(fail_a), .fail_b(fail_b), .fail_z(fail_z), .mul(mbus)
  );

  always #5 clk = ~clk;

  // Stub multiplier: mode 0 fixed latency, 1 operand-dependent latency, 2 never finishes
  int   mode = 0, lat_fix = 5, stub_cnt = 0, cur_lat;
  logic fault = 1'b0;

  always @(posedge clk) begin
    if (mbus.mul_rst)     stub_cnt <= 0;
    else if (mbus.mul_en) stub_cnt <= stub_cnt + 1;
  end

  always_comb begin
    cur_lat = lat_fix;
    if (mode == 1) cur_lat = (mbus.mul_a < 4'd8) ? int'(mbus.mul_a) + 1 : 8;
    mbus.mul_z = 8'(mbus.mul_a) * 8'(mbus.mul_b);
    if (fault) mbus.mul_z[0] = 1'b1;
    mbus.mul_ov = (mode != 2) && mbus.mul_en && !mbus.mul_rst && (stub_cnt == cur_lat - 1);
  end

  typedef struct { logic [3:0] a; logic [3:0] b; } op_t;
  op_t sb_q[$];

  int passed = 0, failed = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: busy-cycle count and operand scoreboard pop on each RUN entry
  int   busy_cyc = 0;
  logic prev_en  = 1'b0;
  always @(negedge clk) begin : mon
    op_t e;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (mbus.mul_en && !prev_en) begin
      if (sb_q.size() == 0) chk("sb_unexpected_run", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("sb_mul_a", 32'(mbus.mul_a), 32'(e.a));
        chk("sb_mul_b", 32'(mbus.mul_b), 32'(e.b));
      end
    end
    prev_en <= mbus.mul_en;
  end

  // Reference model of one run
  int         exp_acc, exp_err;
  logic       exp_tmo;
  logic [3:0] exp_fa, exp_fb;
  logic [7:0] exp_fz;

  task automatic plan_run();
    logic [7:0] s, p, z;
    logic [3:0] a, b;
    int         l;
    s = 8'hA5;
    exp_acc = 0; exp_err = 0; exp_tmo = 1'b0;
    exp_fa = '0; exp_fb = '0; exp_fz = '0;
    sb_q.delete();
    for (int i = 0; i < N; i++) begin
      a = s[3:0];
      b = s[7:4];
      sb_q.push_back('{a: a, b: b});
      p = {4'b0, a} * {4'b0, b};
      z = fault ? (p | 8'h01) : p;
      if (mode == 2)      l = TMO;
      else if (mode == 1) l = (a < 4'd8) ? int'(a) + 1 : 8;
      else                l = lat_fix;
      exp_acc += l;
      if (mode == 2 || z != p) begin
        if (exp_err == 0) begin exp_fa = a; exp_fb = b; exp_fz = z; end
        exp_err++;
      end
      if (mode == 2) exp_tmo = 1'b1;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 400) begin cyc(1); k++; end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_result(input string tag, input int b0);
    chk({tag, "_busy_cycles"}, 32'(busy_cyc - b0), 32'(exp_acc + 2 * N + 1));
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_pass"},    32'(pass), 32'(exp_err == 0));
    chk({tag, "_err"},     32'(err_count), 32'(exp_err));
    chk({tag, "_acc"},     32'(cycle_acc), 32'(exp_acc));
    chk({tag, "_tmo"},     32'(timeout_seen), 32'(exp_tmo));
    chk({tag, "_fail_a"},  32'(fail_a), 32'(exp_fa));
    chk({tag, "_fail_b"},  32'(fail_b), 32'(exp_fb));
    chk({tag, "_fail_z"},  32'(fail_z), 32'(exp_fz));
    chk({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic full_run(input string tag, input int m, input int lat, input logic flt);
    int b0;
    mode = m; lat_fix = lat; fault = flt;
    plan_run();
    b0 = busy_cyc;
    pulse_start();
    chk({tag, "_load_busy"}, 32'(busy), 32'd1);
    chk({tag, "_load_rst"},  32'(mbus.mul_rst), 32'd1);
    wait_done(tag);
    check_result(tag, b0);
  endtask

  initial begin
    int b0;
    cyc(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err",  32'(err_count), 32'd0);
    chk("rst_acc",  32'(cycle_acc), 32'd0);
    chk("rst_tmo",  32'(timeout_seen), 32'd0);
    chk("rst_fail", 32'({fail_a, fail_b, fail_z}), 32'd0);
    chk("rst_ops",  32'({mbus.mul_a, mbus.mul_b}), 32'd0);
    chk("rst_mrst", 32'(mbus.mul_rst), 32'd1);
    chk("rst_men",  32'(mbus.mul_en), 32'd0);
    rst = 1'b1;
    cyc(1);

    full_run("lat5",    0, 5, 1'b0);
    full_run("fault",   0, 5, 1'b1);
    full_run("hang",    2, 5, 1'b0);
    full_run("ov_at_to", 0, TMO, 1'b0);
    full_run("lat1",    0, 1, 1'b0);
    full_run("varlat",  1, 5, 1'b0);

    // second start during RUN must not disturb the run
    mode = 0; lat_fix = 5; fault = 1'b0;
    plan_run();
    b0 = busy_cyc;
    pulse_start();
    cyc(2);
    pulse_start();
    wait_done("restart");
    check_result("restart", b0);

    // reset in the third RUN cycle
    plan_run();
    pulse_start();
    cyc(3);
    chk("mid_en_before", 32'(mbus.mul_en), 32'd1);
    rst = 1'b0;
    cyc(1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_pass", 32'(pass), 32'd0);
    chk("mid_mrst", 32'(mbus.mul_rst), 32'd1);
    chk("mid_men",  32'(mbus.mul_en), 32'd0);
    chk("mid_acc",  32'(cycle_acc), 32'd0);
    chk("mid_err",  32'(err_count), 32'd0);
    chk("mid_ops",  32'({mbus.mul_a, mbus.mul_b}), 32'd0);
    rst = 1'b1;
    sb_q.delete();
    cyc(1);
    full_run("after_rst", 0, 5, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
